mag_cmp_seq: RTL and testbench



---
 rtl/mag_cmp_seq_if.sv | 31 +++
 rtl/mag_cmp_seq.sv | 135 +++++++++++++
 tb/tb_mag_cmp_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mag_cmp_seq_if.sv
// Operand/result handshake bundle for mag_cmp_seq.
//   in_valid/in_ready : operand handshake (a, b, signed_mode travel with it)
//   out_valid/out_ready : result handshake
//   hs, ls, hi, lo, eq : condition flags, meaningful while out_valid = 1
// master = producer of operands / consumer of flags, slave = the comparator.
interface mag_cmp_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             hs;
    logic             ls;
    logic             hi;
    logic             lo;
    logic             eq;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, hs, ls, hi, lo, eq
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, hs, ls, hi, lo, eq
    );
endinterface

// File: rtl/mag_cmp_seq.sv
// Serial magnitude comparator: compares two WIDTH-bit operands one DIGIT-bit
// slice per cycle from the most significant slice down, unsigned or
// two's-complement, with optional exit at the first differing slice.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mag_cmp_seq_if slave (operand and result handshakes, flags)
//   busy   : state is not IDLE
module mag_cmp_seq #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mag_cmp_seq_if.slave bus,
    output logic         busy
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t            state_reg, state_next;
    logic [IDXW-1:0]   idx_reg;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic              sm_reg;
    logic              gt_reg, lt_reg;   // first difference seen during a full scan
    logic              hs_reg, ls_reg, hi_reg, lo_reg, eq_reg;

    logic [DIGIT-1:0]  a_sl [NDIG];
    logic [DIGIT-1:0]  b_sl [NDIG];
    logic [DIGIT-1:0]  top_mask, sa, sb;
    logic              slice_gt, slice_lt, found;
    logic              gt_next, lt_next;
    logic              accept, finish;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_slice
            assign a_sl[gi] = a_reg[gi*DIGIT +: DIGIT];
            assign b_sl[gi] = b_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    always_comb begin
        // Signed compare: flipping the sign bit of the top slice maps
        // two's-complement ordering onto unsigned ordering.
        top_mask = '0;
        if (sm_reg && (idx_reg == IDXW'(NDIG - 1)))
            top_mask[DIGIT-1] = 1'b1;
        sa       = a_sl[idx_reg] ^ top_mask;
        sb       = b_sl[idx_reg] ^ top_mask;
        slice_gt = (sa > sb);
        slice_lt = (sa < sb);
        // Only the most significant difference decides the result.
        found    = gt_reg | lt_reg;
        gt_next  = found ? gt_reg : slice_gt;
        lt_next  = found ? lt_reg : slice_lt;

        state_next = state_reg;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = CMP;
                end
            end
            CMP: begin
                if (((EARLY_EXIT != 0) && (slice_gt || slice_lt)) || (idx_reg == '0)) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            sm_reg  <= 1'b0;
            gt_reg  <= 1'b0;
            lt_reg  <= 1'b0;
            hs_reg  <= 1'b0;
            ls_reg  <= 1'b0;
            hi_reg  <= 1'b0;
            lo_reg  <= 1'b0;
            eq_reg  <= 1'b0;
        end else if (accept) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            sm_reg  <= bus.signed_mode;
            idx_reg <= IDXW'(NDIG - 1);
            gt_reg  <= 1'b0;
            lt_reg  <= 1'b0;
        end else if (state_reg == CMP) begin
            gt_reg <= gt_next;
            lt_reg <= lt_next;
            if (finish) begin
                // Flags only ever change here, so they stay frozen in DONE.
                hi_reg <= gt_next;
                lo_reg <= lt_next;
                eq_reg <= ~gt_next & ~lt_next;
                hs_reg <= gt_next | (~gt_next & ~lt_next);
                ls_reg <= lt_next | (~gt_next & ~lt_next);
            end else begin
                idx_reg <= idx_reg - 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.hs        = hs_reg;
    assign bus.ls        = ls_reg;
    assign bus.hi        = hi_reg;
    assign bus.lo        = lo_reg;
    assign bus.eq        = eq_reg;
    assign busy          = (state_reg != IDLE);
endmodule

// File: tb/tb_mag_cmp_seq.sv
// Directed and swept checks of mag_cmp_seq in four configurations:
//   0: WIDTH=16 DIGIT=4 EARLY_EXIT=1   1: WIDTH=16 DIGIT=4 EARLY_EXIT=0
//   2: WIDTH=8  DIGIT=2 EARLY_EXIT=1   3: WIDTH=12 DIGIT=3 EARLY_EXIT=0
// Flags are packed {hs, ls, hi, lo, eq}.
module tb_mag_cmp_seq;
    localparam logic [4:0] F_GT = 5'b10100;
    localparam logic [4:0] F_LT = 5'b01010;
    localparam logic [4:0] F_EQ = 5'b11001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv   [4];
    logic        orr  [4];
    logic        smd  [4];
    logic [15:0] a_drv[4];
    logic [15:0] b_drv[4];
    logic        ov   [4];
    logic        ir   [4];
    logic        bsy  [4];
    logic [4:0]  flg  [4];

    int checks   = 0;
    int failures = 0;

    mag_cmp_seq_if #(.WIDTH(16)) if0 ();
    mag_cmp_seq_if #(.WIDTH(16)) if1 ();
    mag_cmp_seq_if #(.WIDTH(8))  if2 ();
    mag_cmp_seq_if #(.WIDTH(12)) if3 ();

    mag_cmp_seq #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0), .busy(bsy[0]));
    mag_cmp_seq #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .busy(bsy[1]));
    mag_cmp_seq #(.WIDTH(8),  .DIGIT(2), .EARLY_EXIT(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2), .busy(bsy[2]));
    mag_cmp_seq #(.WIDTH(12), .DIGIT(3), .EARLY_EXIT(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3), .busy(bsy[3]));

    assign if0.in_valid = iv[0];  assign if0.out_ready = orr[0];  assign if0.signed_mode = smd[0];
    assign if0.a = a_drv[0];      assign if0.b = b_drv[0];
    assign if1.in_valid = iv[1];  assign if1.out_ready = orr[1];  assign if1.signed_mode = smd[1];
    assign if1.a = a_drv[1];      assign if1.b = b_drv[1];
    assign if2.in_valid = iv[2];  assign if2.out_ready = orr[2];  assign if2.signed_mode = smd[2];
    assign if2.a = a_drv[2][7:0]; assign if2.b = b_drv[2][7:0];
    assign if3.in_valid = iv[3];  assign if3.out_ready = orr[3];  assign if3.signed_mode = smd[3];
    assign if3.a = a_drv[3][11:0]; assign if3.b = b_drv[3][11:0];

    assign ov[0] = if0.out_valid; assign ir[0] = if0.in_ready;
    assign ov[1] = if1.out_valid; assign ir[1] = if1.in_ready;
    assign ov[2] = if2.out_valid; assign ir[2] = if2.in_ready;
    assign ov[3] = if3.out_valid; assign ir[3] = if3.in_ready;
    assign flg[0] = {if0.hs, if0.ls, if0.hi, if0.lo, if0.eq};
    assign flg[1] = {if1.hs, if1.ls, if1.hi, if1.lo, if1.eq};
    assign flg[2] = {if2.hs, if2.ls, if2.hi, if2.lo, if2.eq};
    assign flg[3] = {if3.hs, if3.ls, if3.hi, if3.lo, if3.eq};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference compare on w-bit values, signed or unsigned.
    function automatic logic [4:0] ref_flags(input logic [15:0] av, input logic [15:0] bv,
                                             input int w, input logic sm);
        longint x, y;
        logic gt, lt, e;
        x = longint'(av) & ((longint'(1) << w) - 1);
        y = longint'(bv) & ((longint'(1) << w) - 1);
        if (sm && x[w-1]) x = x - (longint'(1) << w);
        if (sm && y[w-1]) y = y - (longint'(1) << w);
        gt = (x > y);
        lt = (x < y);
        e  = (x == y);
        return {gt | e, lt | e, gt, lt, e};
    endfunction

    // One transaction on instance k; returns edges from accept to out_valid
    // and the flags seen then. hold=1 leaves the result un-taken.
    task automatic run_txn(input int k, input logic [15:0] av, input logic [15:0] bv,
                           input logic sm, input bit hold, output int lat, output logic [4:0] fl);
        int n;
        @(negedge clk);
        n = 0;
        while (!ir[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        a_drv[k] = av;
        b_drv[k] = bv;
        smd[k]   = sm;
        iv[k]    = 1'b1;
        @(posedge clk);
        #1 iv[k] = 1'b0;
        lat = 0;
        while (!ov[k] && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check_val("out_valid_seen", 32'(ov[k]), 32'd1);
        fl = flg[k];
        if (!hold) begin
            orr[k] = 1'b1;
            @(posedge clk);
            #1 orr[k] = 1'b0;
            check_val("out_valid_drop", 32'(ov[k]), 32'd0);
        end
    endtask

    task automatic directed(input string tag, input int k, input logic [15:0] av, input logic [15:0] bv,
                            input logic sm, input logic [4:0] exp_fl, input int exp_lat);
        int lat;
        logic [4:0] fl;
        run_txn(k, av, bv, sm, 1'b0, lat, fl);
        $display("txn %s inst=%0d a=%h b=%h sm=%0d flags=%b lat=%0d", tag, k, av, bv, sm, fl, lat);
        check_val({tag, "_flags"}, 32'(fl), 32'(exp_fl));
        check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        int lat;
        logic [4:0] fl;
        logic [15:0] av, bv;
        logic sm;

        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; orr[i] = 1'b0; smd[i] = 1'b0; a_drv[i] = '0; b_drv[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(ov[0]), 32'd0);
        check_val("rst_flags", 32'(flg[0]), 32'd0);
        check_val("rst_busy", 32'(bsy[0]), 32'd0);
        check_val("rst_in_ready", 32'(ir[0]), 32'd1);
        @(negedge clk) rst_n = 1'b1;

        directed("eq_1234",      0, 16'h1234, 16'h1234, 1'b0, F_EQ, 4);
        directed("u_8000_ee1",   0, 16'h8000, 16'h7FFF, 1'b0, F_GT, 1);
        directed("s_8000_ee1",   0, 16'h8000, 16'h7FFF, 1'b1, F_LT, 1);
        directed("u_8000_ee0",   1, 16'h8000, 16'h7FFF, 1'b0, F_GT, 4);
        directed("s_8000_ee0",   1, 16'h8000, 16'h7FFF, 1'b1, F_LT, 4);
        directed("u_12f0",       0, 16'h12F0, 16'h12E0, 1'b0, F_GT, 3);
        directed("u_12e0",       0, 16'h12E0, 16'h12F0, 1'b0, F_LT, 3);
        directed("s_ffff",       0, 16'hFFFF, 16'h0001, 1'b1, F_LT, 1);
        directed("u_ffff",       0, 16'hFFFF, 16'h0001, 1'b0, F_GT, 1);
        directed("eq_ee0",       1, 16'hBEEF, 16'hBEEF, 1'b1, F_EQ, 4);
        directed("s_neg_ee0",    1, 16'hFFFE, 16'hFFFF, 1'b1, F_LT, 4);

        // Backpressure: result held while new operands are offered.
        run_txn(0, 16'h0005, 16'h0003, 1'b0, 1'b1, lat, fl);
        check_val("bp_first_flags", 32'(fl), 32'(F_GT));
        check_val("bp_first_lat", 32'(lat), 32'd4);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            a_drv[0] = 16'h0001; b_drv[0] = 16'h0002; smd[0] = 1'b0; iv[0] = 1'b1;
            @(posedge clk);
            #1;
            $display("txn bp_hold cycle=%0d ov=%0d ir=%0d flags=%b", c, ov[0], ir[0], flg[0]);
            check_val("bp_hold_ov", 32'(ov[0]), 32'd1);
            check_val("bp_hold_flags", 32'(flg[0]), 32'(F_GT));
            check_val("bp_hold_in_ready", 32'(ir[0]), 32'd0);
        end
        @(negedge clk) orr[0] = 1'b1;
        @(posedge clk);
        #1 orr[0] = 1'b0;
        check_val("bp_rel_ov", 32'(ov[0]), 32'd0);
        check_val("bp_rel_in_ready", 32'(ir[0]), 32'd1);
        @(posedge clk);
        #1 iv[0] = 1'b0;
        check_val("bp_new_busy", 32'(bsy[0]), 32'd1);
        lat = 0;
        while (!ov[0] && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        $display("txn bp_new a=0001 b=0002 flags=%b lat=%0d", flg[0], lat);
        check_val("bp_new_flags", 32'(flg[0]), 32'(F_LT));
        check_val("bp_new_lat", 32'(lat), 32'd4);
        orr[0] = 1'b1;
        @(posedge clk);
        #1 orr[0] = 1'b0;

        // Reset in the second CMP cycle discards the transaction.
        @(negedge clk);
        a_drv[0] = 16'h1234; b_drv[0] = 16'h1234; smd[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        $display("txn midreset ov=%0d flags=%b busy=%0d ir=%0d", ov[0], flg[0], bsy[0], ir[0]);
        check_val("mr_out_valid", 32'(ov[0]), 32'd0);
        check_val("mr_flags", 32'(flg[0]), 32'd0);
        check_val("mr_busy", 32'(bsy[0]), 32'd0);
        check_val("mr_in_ready", 32'(ir[0]), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        directed("after_reset", 0, 16'h00A0, 16'h00B0, 1'b0, F_LT, 3);

        // Sweeps against the reference compare.
        for (int i = 0; i < 150; i++) begin
            av = 16'($urandom) & 16'h00FF;
            bv = (i % 8 == 0) ? av : (16'($urandom) & 16'h00FF);
            sm = i[0];
            run_txn(2, av, bv, sm, 1'b0, lat, fl);
            $display("txn sweep8 a=%h b=%h sm=%0d flags=%b lat=%0d", av, bv, sm, fl, lat);
            check_val("sweep8_flags", 32'(fl), 32'(ref_flags(av, bv, 8, sm)));
        end
        for (int i = 0; i < 150; i++) begin
            av = 16'($urandom) & 16'h0FFF;
            bv = (i % 8 == 0) ? av : (16'($urandom) & 16'h0FFF);
            sm = i[0];
            run_txn(3, av, bv, sm, 1'b0, lat, fl);
            $display("txn sweep12 a=%h b=%h sm=%0d flags=%b lat=%0d", av, bv, sm, fl, lat);
            check_val("sweep12_flags", 32'(fl), 32'(ref_flags(av, bv, 12, sm)));
            check_val("sweep12_lat", 32'(lat), 32'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
